ccsds123_byte_unpacker: RTL and testbench

Upstream feeder for ccsds123_top. Converts a little-endian 8-bit AXI-Stream byte stream of raw image samples, already in BIP order (band index fastest), into PIPELINES-lane sample words of PIPELINES*D bits for the compressor's s_axis port. It counts samples per image, zero-pads the final partial word, and flags it with tlast.

---
 rtl/ccsds123_byte_unpacker.sv | 107 ++++++++++
 tb/tb_ccsds123_byte_unpacker.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccsds123_byte_unpacker.sv
// ccsds123_byte_unpacker: packs a little-endian AXI-Stream byte stream of BIP-ordered
// samples into PIPELINES-lane words of PIPELINES*D bits for the compressor input.
//   clk, areset          : clock, synchronous active-high reset
//   s_axis_tdata/tvalid  : input bytes, little-endian within each sample
//   s_axis_tready        : registered; low only while a completed word is parked
//   m_axis_tdata/tvalid  : assembled word, lane 0 in bits [D-1:0]
//   m_axis_tready        : downstream ready
//   m_axis_tlast         : word holds the image's final sample (unused lanes zero)
//   image_done           : one-cycle pulse after the tlast word is accepted
module ccsds123_byte_unpacker #(
    parameter int PIPELINES = 1,
    parameter int D = 16,
    parameter int NX = 8,
    parameter int NY = 8,
    parameter int NZ = 8
) (
    input  logic                   clk,
    input  logic                   areset,
    input  logic [7:0]             s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [PIPELINES*D-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   image_done
);
    localparam int SAMPLE_BYTES = (D + 7) / 8;
    localparam int TOTAL_SAMPLES = NX * NY * NZ;
    localparam int W = PIPELINES * D;
    localparam int BW = $clog2(SAMPLE_BYTES + 1);
    localparam int LW = $clog2(PIPELINES + 1);
    localparam int CW = $clog2(TOTAL_SAMPLES + 1);

    typedef enum logic {S_ASSEMBLE, S_WAIT} state_t;

    state_t                    state;
    logic [BW-1:0]             byte_idx;
    logic [LW-1:0]             lane_idx;
    logic [CW-1:0]             sample_cnt;
    logic [W-1:0]              buffer;
    logic                      pend_last;
    logic [SAMPLE_BYTES*8-1:0] lane_bytes;
    logic [W-1:0]              word_next;
    logic                      accept, out_free, last_byte, last_lane, last_sample, complete;

    assign accept      = s_axis_tvalid && s_axis_tready;
    assign out_free    = !m_axis_tvalid || m_axis_tready;
    assign last_byte   = byte_idx == BW'(SAMPLE_BYTES - 1);
    assign last_lane   = lane_idx == LW'(PIPELINES - 1);
    assign last_sample = sample_cnt == CW'(TOTAL_SAMPLES - 1);
    assign complete    = accept && last_byte && (last_lane || last_sample);

    // Bytes land in a whole-byte lane image; slicing to D drops the excess top bits.
    always_comb begin
        lane_bytes = '0;
        lane_bytes[byte_idx*8 +: 8] = s_axis_tdata;
        word_next = buffer | (W'(lane_bytes[D-1:0]) << (lane_idx * D));
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            state         <= S_ASSEMBLE;
            byte_idx      <= '0;
            lane_idx      <= '0;
            sample_cnt    <= '0;
            buffer        <= '0;
            pend_last     <= 1'b0;
            s_axis_tready <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            image_done    <= 1'b0;
        end else begin
            image_done <= m_axis_tvalid && m_axis_tready && m_axis_tlast;
            // tready comes from state only: it drops after a word is parked, rises once it moves out
            s_axis_tready <= state == S_ASSEMBLE ? !(complete && !out_free) : out_free;
            if (m_axis_tready)
                m_axis_tvalid <= 1'b0;
            if (state == S_ASSEMBLE) begin
                if (accept) begin
                    byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
                    if (last_byte) begin
                        sample_cnt <= last_sample ? '0 : sample_cnt + 1'b1;
                        lane_idx   <= (last_lane || last_sample) ? '0 : lane_idx + 1'b1;
                    end
                    buffer <= word_next;
                    if (complete && out_free) begin
                        m_axis_tdata  <= word_next;
                        m_axis_tlast  <= last_sample;
                        m_axis_tvalid <= 1'b1;
                        buffer        <= '0;
                    end else if (complete) begin
                        pend_last <= last_sample;
                        state     <= S_WAIT;
                    end
                end
            end else if (out_free) begin
                m_axis_tdata  <= buffer;
                m_axis_tlast  <= pend_last;
                m_axis_tvalid <= 1'b1;
                buffer        <= '0;
                state         <= S_ASSEMBLE;
            end
        end
    end
endmodule

// File: tb/tb_ccsds123_byte_unpacker.sv
// tb_ccsds123_byte_unpacker: vector table, corner sequences and randomized model check.
module tb_ccsds123_byte_unpacker;
    localparam int A_P = 2;
    localparam int A_TOTAL = 6;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } word_t;

    typedef struct {
        logic [7:0]  b;
        logic        v;
        logic [31:0] d;
        logic        l;
    } vec_t;

    logic clk = 1'b0;
    logic areset = 1'b1;

    logic [7:0]  a_data = '0;
    logic        a_valid = 1'b0, a_stready, a_mvalid, a_mready = 1'b1, a_mlast, a_done;
    logic [31:0] a_mdata;

    logic [7:0]  b_data = '0;
    logic        b_valid = 1'b0, b_stready, b_mvalid, b_mlast, b_done;
    logic [63:0] b_mdata;

    logic [7:0]  c_data = '0;
    logic        c_valid = 1'b0, c_stready, c_mvalid, c_mlast, c_done;
    logic [11:0] c_mdata;

    int checks = 0, failures = 0, done_cnt = 0, drop_cnt = 0, rmode = 0;
    logic watch = 1'b0;
    logic hold_prev = 1'b0, hold_l;
    logic [31:0] hold_d;
    word_t got_q[$], exp_q[$];
    logic [7:0] img[$];

    always #5 clk = ~clk;

    ccsds123_byte_unpacker #(.PIPELINES(2), .D(16), .NX(2), .NY(1), .NZ(3)) dut_a (
        .clk(clk), .areset(areset), .s_axis_tdata(a_data), .s_axis_tvalid(a_valid),
        .s_axis_tready(a_stready), .m_axis_tdata(a_mdata), .m_axis_tvalid(a_mvalid),
        .m_axis_tready(a_mready), .m_axis_tlast(a_mlast), .image_done(a_done));

    ccsds123_byte_unpacker #(.PIPELINES(4), .D(16), .NX(2), .NY(1), .NZ(3)) dut_b (
        .clk(clk), .areset(areset), .s_axis_tdata(b_data), .s_axis_tvalid(b_valid),
        .s_axis_tready(b_stready), .m_axis_tdata(b_mdata), .m_axis_tvalid(b_mvalid),
        .m_axis_tready(1'b1), .m_axis_tlast(b_mlast), .image_done(b_done));

    ccsds123_byte_unpacker #(.PIPELINES(1), .D(12), .NX(2), .NY(1), .NZ(1)) dut_c (
        .clk(clk), .areset(areset), .s_axis_tdata(c_data), .s_axis_tvalid(c_valid),
        .s_axis_tready(c_stready), .m_axis_tdata(c_mdata), .m_axis_tvalid(c_mvalid),
        .m_axis_tready(1'b1), .m_axis_tlast(c_mlast), .image_done(c_done));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference: once a full image of bytes is in, slice it into samples and lanes.
    task automatic model_byte(input logic [7:0] b);
        img.push_back(b);
        if (img.size() == A_TOTAL * 2) begin
            for (int w = 0; w < (A_TOTAL + A_P - 1) / A_P; w++) begin
                logic [31:0] word;
                word = '0;
                for (int l = 0; l < A_P; l++) begin
                    int s;
                    s = w * A_P + l;
                    if (s < A_TOTAL)
                        word |= 32'({img[2*s+1], img[2*s]}) << (16 * l);
                end
                exp_q.push_back('{word, w == (A_TOTAL + A_P - 1) / A_P - 1});
            end
            img.delete();
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        a_valid = 1'b1;
        a_data = b;
        @(negedge clk);
        while (!a_stready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!a_stready) begin
            failures++;
            $display("FAIL send_timeout byte=%h", b);
        end
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        model_byte(b);
    endtask

    task automatic flush(input string nm, input int exp_done);
        int n;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 2000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk({nm, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({nm, "_data"}, 64'(got_q[i].d), 64'(exp_q[i].d));
            chk({nm, "_last"}, 64'(got_q[i].l), 64'(exp_q[i].l));
        end
        chk({nm, "_done"}, 64'(done_cnt), 64'(exp_done));
        got_q.delete();
        exp_q.delete();
        done_cnt = 0;
    endtask

    // Downstream ready: 0 always-1, 1 random, 2 toggle, 3 held low.
    initial forever begin
        @(posedge clk);
        #2;
        case (rmode)
            1: a_mready = 1'($urandom_range(0, 1));
            2: a_mready = ~a_mready;
            3: a_mready = 1'b0;
            default: a_mready = 1'b1;
        endcase
    end

    initial forever begin
        @(negedge clk);
        if (hold_prev) begin
            chk("hold_valid", 64'(a_mvalid), 64'd1);
            chk("hold_data", 64'(a_mdata), 64'(hold_d));
            chk("hold_last", 64'(a_mlast), 64'(hold_l));
        end
        hold_prev = !areset && a_mvalid && !a_mready;
        hold_d = a_mdata;
        hold_l = a_mlast;
        if (!areset && a_mvalid && a_mready)
            got_q.push_back('{a_mdata, a_mlast});
        if (a_done)
            done_cnt++;
        if (watch && !a_stready)
            drop_cnt++;
    end

    initial begin
        vec_t tbl[12];
        for (int i = 0; i < 12; i++)
            tbl[i] = '{8'(i + 1), 1'b0, 32'h0, 1'b0};
        tbl[3]  = '{8'h04, 1'b1, 32'h04030201, 1'b0};
        tbl[7]  = '{8'h08, 1'b1, 32'h08070605, 1'b0};
        tbl[11] = '{8'h0C, 1'b1, 32'h0C0B0A09, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_tready", 64'(a_stready), 64'd0);
        chk("rst_m_tvalid", 64'(a_mvalid), 64'd0);
        chk("rst_m_tdata", 64'(a_mdata), 64'd0);
        chk("rst_m_tlast", 64'(a_mlast), 64'd0);
        chk("rst_image_done", 64'(a_done), 64'd0);
        areset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_s_tready", 64'(a_stready), 64'd1);

        for (int i = 0; i < 12; i++) begin
            send(tbl[i].b);
            chk("tbl_valid", 64'(a_mvalid), 64'(tbl[i].v));
            if (tbl[i].v) begin
                chk("tbl_data", 64'(a_mdata), 64'(tbl[i].d));
                chk("tbl_last", 64'(a_mlast), 64'(tbl[i].l));
            end
        end
        @(posedge clk);
        #1;
        chk("tbl_image_done_pulse", 64'(a_done), 64'd1);
        @(posedge clk);
        #1;
        chk("tbl_image_done_end", 64'(a_done), 64'd0);
        flush("full_words", 1);

        rmode = 3;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 4; i++) send(8'(i));
        chk("bp_first_valid", 64'(a_mvalid), 64'd1);
        chk("bp_first_data", 64'(a_mdata), 64'h04030201);
        for (int i = 5; i <= 8; i++) send(8'(i));
        chk("bp_wait_s_tready", 64'(a_stready), 64'd0);
        chk("bp_held_data", 64'(a_mdata), 64'h04030201);
        rmode = 2;
        for (int i = 9; i <= 12; i++) send(8'(i));
        flush("backpressure", 1);
        rmode = 0;

        repeat (2) @(posedge clk);
        #1;
        for (int i = 1; i <= 5; i++) send(8'(i));
        repeat (4) @(posedge clk);
        #1;
        got_q.delete();
        exp_q.delete();
        img.delete();
        done_cnt = 0;
        areset = 1'b1;
        @(posedge clk);
        #1;
        areset = 1'b0;
        chk("midrst_m_tvalid", 64'(a_mvalid), 64'd0);
        for (int i = 0; i < 12; i++) send(8'(8'h21 + i));
        flush("reset_mid_image", 1);

        watch = 1'b1;
        for (int i = 0; i < 24; i++) send(8'($urandom_range(0, 255)));
        watch = 1'b0;
        chk("b2b_tready_drops", 64'(drop_cnt), 64'd0);
        flush("back_to_back", 2);

        rmode = 1;
        for (int i = 0; i < 240; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(8'($urandom_range(0, 255)));
        end
        flush("random", 20);
        rmode = 0;

        for (int i = 0; i < 12; i++) begin
            b_valid = 1'b1;
            b_data = 8'(i + 1);
            @(posedge clk);
            #1;
            if (i == 7) begin
                chk("p4_word0_valid", 64'(b_mvalid), 64'd1);
                chk("p4_word0_data", b_mdata, 64'h0807060504030201);
                chk("p4_word0_last", 64'(b_mlast), 64'd0);
            end
            if (i == 11) begin
                chk("p4_word1_valid", 64'(b_mvalid), 64'd1);
                chk("p4_word1_data", b_mdata, 64'h000000000C0B0A09);
                chk("p4_word1_last", 64'(b_mlast), 64'd1);
            end
        end
        b_valid = 1'b0;

        for (int i = 0; i < 4; i++) begin
            logic [31:0] cb;
            cb = 32'h1234FFFF;
            c_valid = 1'b1;
            c_data = cb[8*i +: 8];
            @(posedge clk);
            #1;
            if (i == 1) begin
                chk("d12_word0_data", 64'(c_mdata), 64'hFFF);
                chk("d12_word0_last", 64'(c_mlast), 64'd0);
            end
            if (i == 3) begin
                chk("d12_word1_data", 64'(c_mdata), 64'h234);
                chk("d12_word1_last", 64'(c_mlast), 64'd1);
            end
        end
        c_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
